modulo_varredura_matriz: RTL
============================

Name: modulo_varredura_matriz

Overview:
- Downstream consumer of the 35-bit LED-matrix pattern register: takes its 35-bit m_out word and time-multiplexes it onto a 5-column x 7-row LED dot matrix.
- Drives exactly one column at a time, with that column's 7 row bits, then a short all-off blanking gap to suppress ghosting.
- Snapshots the pattern once per frame so that a register update mid-frame never tears the displayed image.

Parameters:
- DIV_MAX, 3, SHOW dwell per column is DIV_MAX+1 clk cycles; legal range 0 to 2^16-1.
- BLANK_CYC, 1, all-off cycles between columns; 0 means no gap; legal range 0 to 255.
- COL_ACTIVE_LOW, 1, 1 means the selected column is driven 0 and idle columns are 1; 0 inverts this.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  scan enable, level-sensitive.
- m_in  input  35  pattern word from the matrix register.
- col  output  5  column select, one-hot active per COL_ACTIVE_LOW; col[0] is column 0.
- lin  output  7  row drive, active-high; lin[0] is row 0.
- frame_tick  output  1  one-cycle pulse at the start of each frame after the first.

Behaviour:
- Bit mapping: column c, row r comes from m_in[34 - (7*c + r)]. Column 0 is m_in[34:28] with row 0 at bit 34; column 4 is m_in[6:0].
- State: FSM {IDLE, SHOW, BLANK}, plus col_idx (0..4), div counter (16b), blank counter (8b) and a 35-bit snapshot register. All are registered; outputs are decoded from registered state, so there is no combinational path from m_in or en to any output.
- Reset (clr=1, asynchronous) forces:
  - state=IDLE, col_idx=0, both counters=0, snapshot=0, frame_tick=0;
  - col all inactive (5'b11111 when COL_ACTIVE_LOW=1), lin=0.
- IDLE: col inactive, lin=0. At a rising edge with en=1: snapshot<=m_in, col_idx<=0, div<=0, state<=SHOW. Column 0 is valid immediately after that edge.
- SHOW:
  - col = col_idx active; lin = snapshot slice for col_idx.
  - div increments each cycle.
  - When div==DIV_MAX: div<=0; go to BLANK if BLANK_CYC>0, otherwise perform the column advance at this same edge.
- BLANK:
  - col inactive, lin=0; blank counter increments.
  - When the counter reaches BLANK_CYC-1: counter<=0, perform the column advance, state<=SHOW.
- Column advance:
  - If col_idx<4: col_idx<=col_idx+1.
  - If col_idx==4: col_idx<=0, snapshot<=m_in (sampled at this edge), and frame_tick=1 for exactly the first cycle of the new column-0 SHOW.
- Timing:
  - Column period is DIV_MAX+1+BLANK_CYC cycles; frame period is 5 times that.
  - frame_tick is never asserted for the first frame after leaving IDLE.
- Clearing en: en=0 sampled at any edge sends the block to IDLE at that edge. Outputs go inactive, counters clear, frame_tick=0, and the snapshot is held. Re-enabling restarts at column 0 with a fresh snapshot.
- Pattern changes: a change on m_in during a frame has no visible effect until the next frame boundary.
- Reset mid-scan: reset is immediate and asynchronous. No partial column is shown after clr deasserts until en is sampled high.
- Overlap: at most one column is ever active in any cycle; lin is 0 whenever no column is active.

Decomposition:
- Shared package modulo_matriz_pkg holds:
  - N_COLS=5, N_ROWS=7, N_BITS=35;
  - state encoding IDLE=2'b00, SHOW=2'b01, BLANK=2'b10;
  - the bit-index function 34-(7*c+r).
- One sub-module, modulo_divisor: a parameterised up-counter with asynchronous clr, synchronous clear, and a terminal-count flag, instantiated twice (dwell and blank).

Test Plan:
- Reset: clr pulsed mid-SHOW -> col=5'b11111, lin=0, frame_tick=0 within the same cycle, asynchronously, before the next clk edge.
- Basic scan: DIV_MAX=3, BLANK_CYC=1, m_in=35'h7F_0000000 (column 0 all on), en=1.
  - Col pattern repeats every 25 cycles: column 0 active 4 cycles with lin=7'h7F, 1 blank cycle, then columns 1-4 with lin=0.
  - frame_tick pulses at cycle 25, then every 25 cycles.
- Bit order: m_in has only bit 34 set -> lin=7'b0000001 during column 0 only. m_in has only bit 0 set -> lin=7'b1000000 during column 4 only.
- Tear-free update: m_in changes from all-ones to all-zeros while column 2 is showing -> columns 3 and 4 still show 7'h7F; the next frame shows lin=0 everywhere.
- Enable control: en dropped during BLANK of column 3 -> IDLE next cycle with outputs inactive. en reasserted -> column 0 is the first active column, and no frame_tick appears in that first frame.
- No blanking: BLANK_CYC=0, DIV_MAX=0 -> the column changes every cycle (0,1,2,3,4,0), there is never an all-inactive cycle, and frame_tick fires every 5 cycles.

Source files
------------

// File: rtl/modulo_matriz_pkg.sv
// Shared definitions for the LED dot-matrix column scanner.
package modulo_matriz_pkg;

    localparam int N_COLS = 5;
    localparam int N_ROWS = 7;
    localparam int N_BITS = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHOW  = 2'b01,
        BLANK = 2'b10
    } state_t;

    // Pattern bit that drives column c, row r. Column 0 sits at the top of the word.
    function automatic logic [5:0] bit_index(input logic [2:0] c, input logic [2:0] r);
        return 6'(N_BITS - 1 - (N_ROWS * int'(c) + int'(r)));
    endfunction

endpackage

// File: rtl/modulo_divisor.sv
// Free-running up-counter that wraps after MAX, with a terminal-count flag.
module modulo_divisor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MAX   = 0
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Count while enabled, wrap to zero on the terminal value; synchronous clear wins.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (r_count == LP_MAX) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    // Flag the last counting cycle only while the counter is actually advancing.
    assign o_tc = i_inc && (r_count == LP_MAX);

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Time-multiplexes a 35-bit pattern onto a 5-column x 7-row LED matrix,
// one column at a time with optional blanking, snapshotting once per frame.
module modulo_varredura_matriz
    import modulo_matriz_pkg::*;
#(
    parameter int unsigned DIV_MAX        = 3,
    parameter int unsigned BLANK_CYC      = 1,
    parameter bit          COL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [N_BITS-1:0]   m_in,
    output logic [N_COLS-1:0]   col,
    output logic [N_ROWS-1:0]   lin,
    output logic                frame_tick
);

    localparam int unsigned LP_BLANK_MAX = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic [2:0]  LP_LAST_COL  = 3'(N_COLS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_col_idx;
    logic [2:0]          w_col_idx_nxt;
    logic [N_BITS-1:0]   r_snapshot;
    logic                r_frame_tick;
    logic                w_tick_nxt;
    logic                w_load_snap;
    logic                w_advance;
    logic                w_div_tc;
    logic                w_blank_tc;
    logic                w_in_show;
    logic                w_in_blank;
    logic [N_COLS-1:0]   w_sel;
    logic [N_ROWS-1:0]   w_lin;

    assign w_in_show  = (r_state == SHOW);
    assign w_in_blank = (r_state == BLANK);

    modulo_divisor #(
        .WIDTH (16),
        .MAX   (DIV_MAX)
    ) u_div_dwell (
        .clk     (clk),
        .clr     (clr),
        .i_clear (!en || !w_in_show),
        .i_inc   (w_in_show),
        .o_tc    (w_div_tc)
    );

    modulo_divisor #(
        .WIDTH (8),
        .MAX   (LP_BLANK_MAX)
    ) u_div_blank (
        .clk     (clk),
        .clr     (clr),
        .i_clear (!en || !w_in_blank),
        .i_inc   (w_in_blank),
        .o_tc    (w_blank_tc)
    );

    // Next-state logic: start, dwell/blank sequencing and the column advance at frame wrap.
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_load_snap   = 1'b0;
        w_tick_nxt    = 1'b0;
        w_advance     = 1'b0;
        if (!en) begin
            w_state_nxt   = IDLE;
            w_col_idx_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt   = SHOW;
                    w_col_idx_nxt = '0;
                    w_load_snap   = 1'b1;
                end
                SHOW: begin
                    if (w_div_tc) begin
                        if (BLANK_CYC > 0) begin
                            w_state_nxt = BLANK;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (w_blank_tc) begin
                        w_state_nxt = SHOW;
                        w_advance   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            if (w_advance) begin
                if (r_col_idx == LP_LAST_COL) begin
                    w_col_idx_nxt = '0;
                    w_load_snap   = 1'b1;
                    w_tick_nxt    = 1'b1;
                end else begin
                    w_col_idx_nxt = r_col_idx + 3'd1;
                end
            end
        end
    end

    // State, column index, frame snapshot and tick registers.
    // NOTE: the snapshot is ordinary flop storage, not a memory array, so it takes the reset too.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= IDLE;
            r_col_idx    <= '0;
            r_snapshot   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col_idx    <= w_col_idx_nxt;
            r_frame_tick <= w_tick_nxt;
            if (w_load_snap) begin
                r_snapshot <= m_in;
            end
        end
    end

    // Decode column select and row drive purely from registered state.
    always_comb begin
        w_sel = '0;
        w_lin = '0;
        if (w_in_show && (r_col_idx <= LP_LAST_COL)) begin
            w_sel = N_COLS'(1) << r_col_idx;
            for (int r = 0; r < N_ROWS; r++) begin
                w_lin[r] = r_snapshot[bit_index(r_col_idx, 3'(r))];
            end
        end
    end

    assign col        = COL_ACTIVE_LOW ? ~w_sel : w_sel;
    assign lin        = w_lin;
    assign frame_tick = r_frame_tick;

endmodule
